// File: rtl/fb_controller.sv
// rtl/fb_controller.sv - Avalon-MM to pixel-memory engine command bridge (optional FB_BOUNDS_CHECK_EN)
module fb_controller #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] ava_writedata,
    input  logic        ava_write,
    input  logic        ava_read,
    output logic        ava_waitrequest,
    output logic [63:0] ava_readdata,
    output logic        ava_readdatavalid,
    output logic        do_write,
    output logic        do_read,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic [31:0] write_rgb,
    input  logic [31:0] read_rgb,
    input  logic        busy,
    input  logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT,
        RD_RESP
    } state_t;

`ifdef FB_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_t      state;
    logic [11:0] x_q;
    logic [11:0] y_q;
    logic [31:0] rgb_q;
    logic        out_of_range;
    logic        unused_cmd_bits;

    // Top byte of the command word carries nothing for this block.
    assign unused_cmd_bits = ^ava_writedata[63:56];

    // Latched coordinates outside the frame are dropped when bounds checking is built in.
    assign out_of_range = BOUNDS_EN &&
                          ((32'(x_q) >= 32'(WIDTH)) || (32'(y_q) >= 32'(HEIGHT)));

    assign pix_x     = {4'd0, x_q};
    assign pix_y     = {4'd0, y_q};
    assign write_rgb = rgb_q;

    // Requests are only taken in IDLE; held high throughout reset.
    assign ava_waitrequest = (state != IDLE) || !rst;

    // Engine commands are decoded from the REQ states so they can never leak into other states.
    assign do_write = (state == WR_REQ) && !busy && !out_of_range;
    assign do_read  = (state == RD_REQ) && !busy && !out_of_range;

    // Main transaction FSM with the command latch and read response registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            x_q               <= '0;
            y_q               <= '0;
            rgb_q             <= '0;
            ava_readdata      <= '0;
            ava_readdatavalid <= 1'b0;
        end else begin
            ava_readdatavalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (ava_write || ava_read) begin
                        x_q   <= ava_writedata[55:44];
                        y_q   <= ava_writedata[43:32];
                        rgb_q <= ava_writedata[31:0];
                        // Write has priority; a concurrent read waits under waitrequest.
                        state <= ava_write ? WR_REQ : RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (out_of_range) begin
                        state <= IDLE;
                    end else if (!busy) begin
                        state <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (done) begin
                        state <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (out_of_range) begin
                        ava_readdata      <= {8'h00, x_q, y_q, 32'h0};
                        ava_readdatavalid <= 1'b1;
                        state             <= RD_RESP;
                    end else if (!busy) begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (done) begin
                        ava_readdata      <= {8'h00, x_q, y_q, read_rgb};
                        ava_readdatavalid <= 1'b1;
                        state             <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_controller.sv
// tb/tb_fb_controller.sv - scoreboard testbench for fb_controller
module tb_fb_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] ava_writedata = '0;
    logic        ava_write = 1'b0;
    logic        ava_read = 1'b0;
    logic        ava_waitrequest;
    logic [63:0] ava_readdata;
    logic        ava_readdatavalid;
    logic        do_write;
    logic        do_read;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic [31:0] write_rgb;
    logic [31:0] read_rgb = '0;
    logic        busy = 1'b0;
    logic        done = 1'b0;

    int checks = 0;
    int failures = 0;

    // Expected engine commands: {is_read, x16, y16, rgb32}
    logic [64:0] cmd_q[$];
    // Expected read responses
    logic [63:0] resp_q[$];

    logic        eng_en = 1'b1;
    logic [31:0] eng_rgb = '0;

    fb_controller #(.WIDTH(640), .HEIGHT(480)) dut (
        .clk(clk),
        .rst(rst),
        .ava_writedata(ava_writedata),
        .ava_write(ava_write),
        .ava_read(ava_read),
        .ava_waitrequest(ava_waitrequest),
        .ava_readdata(ava_readdata),
        .ava_readdatavalid(ava_readdatavalid),
        .do_write(do_write),
        .do_read(do_read),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .write_rgb(write_rgb),
        .read_rgb(read_rgb),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Engine model: done pulses two cycles after a command is seen.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && eng_en && (do_write || do_read)) begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                done = 1'b1;
                read_rgb = eng_rgb;
                @(posedge clk); #1;
                done = 1'b0;
                read_rgb = '0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT produces a command or response.
    always @(negedge clk) begin
        if (rst) begin
            if (do_write && do_read) begin
                checks++;
                failures++;
                $display("FAIL cmd_exclusive do_write=%b do_read=%b required not both", do_write, do_read);
            end
            if (do_write || do_read) begin
                checks++;
                if (cmd_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_cmd rd=%b x=%0d y=%0d required none", do_read, pix_x, pix_y);
                end else begin
                    logic [64:0] exp_c;
                    exp_c = cmd_q.pop_front();
                    if ({do_read, pix_x, pix_y, write_rgb} !== exp_c) begin
                        failures++;
                        $display("FAIL cmd got=%h required=%h", {do_read, pix_x, pix_y, write_rgb}, exp_c);
                    end
                end
            end
            if (ava_readdatavalid) begin
                checks++;
                if (resp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_readdatavalid data=%h required none", ava_readdata);
                end else begin
                    logic [63:0] exp_r;
                    exp_r = resp_q.pop_front();
                    if (ava_readdata !== exp_r) begin
                        failures++;
                        $display("FAIL readdata got=%h required=%h", ava_readdata, exp_r);
                    end
                end
            end
        end
    end

    function automatic logic [63:0] mk_cmd(input logic [11:0] x, input logic [11:0] y, input logic [31:0] rgb);
        return {8'h5A, x, y, rgb};
    endfunction

    // Hold the given strobes until the DUT accepts, bounded.
    task automatic issue(input logic wr, input logic rd, input logic [63:0] data, output int accept_cycle);
        int n;
        bit ok;
        ok = 1'b0;
        accept_cycle = 0;
        @(posedge clk); #1;
        ava_writedata = data;
        ava_write = wr;
        ava_read = rd;
        for (n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (!ava_waitrequest) ok = 1'b1;
            @(posedge clk); #1;
        end
        accept_cycle = n;
        ava_write = 1'b0;
        ava_read = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout waitrequest=%b required 0", ava_waitrequest);
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (!ava_waitrequest && cmd_q.size() == 0 && resp_q.size() == 0 && !done) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s_idle_timeout waitrequest=%b cmds_left=%0d resps_left=%0d required idle/0/0",
                     name, ava_waitrequest, cmd_q.size(), resp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({ava_waitrequest, ava_readdatavalid, do_write, do_read} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b required=1000", {ava_waitrequest, ava_readdatavalid, do_write, do_read});
        end
        checks++;
        if ({ava_readdata, pix_x, pix_y, write_rgb} !== '0) begin
            failures++;
            $display("FAIL reset_data readdata=%h x=%h y=%h rgb=%h required 0", ava_readdata, pix_x, pix_y, write_rgb);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ava_waitrequest !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_waitrequest got=%b required=0", ava_waitrequest);
        end
    endtask

    task automatic test_write();
        int acc;
        cmd_q.push_back({1'b0, 16'd100, 16'd200, 32'hAABBCCDD});
        issue(1'b1, 1'b0, mk_cmd(12'd100, 12'd200, 32'hAABBCCDD), acc);
        wait_idle("write");
        checks++;
        if ({pix_x, pix_y, write_rgb} !== {16'd100, 16'd200, 32'hAABBCCDD}) begin
            failures++;
            $display("FAIL write_hold got=%h required=%h", {pix_x, pix_y, write_rgb}, {16'd100, 16'd200, 32'hAABBCCDD});
        end
    endtask

    task automatic test_read();
        int acc;
        eng_rgb = 32'h12345678;
        cmd_q.push_back({1'b1, 16'd100, 16'd200, 32'h0});
        resp_q.push_back(64'h00_064_0C8_12345678);
        issue(1'b0, 1'b1, mk_cmd(12'd100, 12'd200, 32'h0), acc);
        wait_idle("read");
        // Readdata must persist after the strobe.
        repeat (3) @(negedge clk);
        checks++;
        if (ava_readdata !== 64'h00_064_0C8_12345678) begin
            failures++;
            $display("FAIL read_hold got=%h required=%h", ava_readdata, 64'h00_064_0C8_12345678);
        end
    endtask

    task automatic test_busy_stall();
        int acc;
        busy = 1'b1;
        cmd_q.push_back({1'b0, 16'd7, 16'd9, 32'h0BADF00D});
        issue(1'b1, 1'b0, mk_cmd(12'd7, 12'd9, 32'h0BADF00D), acc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (do_write !== 1'b0 || ava_waitrequest !== 1'b1) begin
                failures++;
                $display("FAIL stall_cycle%0d do_write=%b waitreq=%b required 0/1", i, do_write, ava_waitrequest);
            end
        end
        @(posedge clk); #1;
        busy = 1'b0;
        wait_idle("stall");
    endtask

    task automatic test_simultaneous();
        int acc;
        eng_rgb = 32'hCAFEBABE;
        cmd_q.push_back({1'b0, 16'd33, 16'd44, 32'h11223344});
        cmd_q.push_back({1'b1, 16'd33, 16'd44, 32'h11223344});
        resp_q.push_back({8'h00, 12'd33, 12'd44, 32'hCAFEBABE});
        issue(1'b1, 1'b1, mk_cmd(12'd33, 12'd44, 32'h11223344), acc);
        // Read stays pending; hold it until taken.
        issue(1'b0, 1'b1, mk_cmd(12'd33, 12'd44, 32'h11223344), acc);
        checks++;
        if (acc < 3) begin
            failures++;
            $display("FAIL simul_read_wait waited=%0d required>=3", acc);
        end
        wait_idle("simul");
    endtask

    task automatic test_bounds();
        int acc;
`ifdef FB_BOUNDS_CHECK_EN
        issue(1'b1, 1'b0, mk_cmd(12'd700, 12'd10, 32'hDEADBEEF), acc);
        wait_idle("bounds_wr");
        resp_q.push_back({8'h00, 12'd5, 12'd480, 32'h0});
        issue(1'b0, 1'b1, mk_cmd(12'd5, 12'd480, 32'h0), acc);
        @(negedge clk);
        checks++;
        if (ava_readdatavalid !== 1'b1) begin
            failures++;
            $display("FAIL bounds_rd_latency readdatavalid=%b required=1", ava_readdatavalid);
        end
        wait_idle("bounds_rd");
`else
        cmd_q.push_back({1'b0, 16'd700, 16'd10, 32'hDEADBEEF});
        issue(1'b1, 1'b0, mk_cmd(12'd700, 12'd10, 32'hDEADBEEF), acc);
        wait_idle("bounds_wr");
`endif
        checks++;
        if (pix_x !== 16'd700) begin
            failures++;
            $display("FAIL bounds_pix_x got=%0d required=700", pix_x);
        end
    endtask

    task automatic test_reset_mid_read();
        int acc;
        eng_en = 1'b0;
        cmd_q.push_back({1'b1, 16'd1, 16'd2, 32'h0});
        issue(1'b0, 1'b1, mk_cmd(12'd1, 12'd2, 32'h0), acc);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({ava_waitrequest, ava_readdatavalid, do_read, pix_x, pix_y} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL midreset_clear wr=%b rdv=%b do_read=%b x=%0d y=%0d required 1/0/0/0/0",
                     ava_waitrequest, ava_readdatavalid, do_read, pix_x, pix_y);
        end
        @(posedge clk); #1;
        done = 1'b1;
        read_rgb = 32'hFFFFFFFF;
        @(posedge clk); #1;
        done = 1'b0;
        read_rgb = '0;
        rst = 1'b1;
        eng_en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ava_waitrequest !== 1'b0 || ava_readdatavalid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_after waitreq=%b rdv=%b required 0/0", ava_waitrequest, ava_readdatavalid);
        end
        cmd_q.push_back({1'b0, 16'd639, 16'd479, 32'h01020304});
        issue(1'b1, 1'b0, mk_cmd(12'd639, 12'd479, 32'h01020304), acc);
        wait_idle("postreset");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_busy_stall();
        test_simultaneous();
        test_bounds();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_q.size() != 0 || resp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain cmds=%0d resps=%0d required 0/0", cmd_q.size(), resp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
